mem_sweep_reader: RTL
=====================

Name: mem_sweep_reader

Overview:
Read-side initiator for the block-RAM memory wrapper (1-cycle registered read, raddr in, dout out). On a start pulse it sweeps every address 0..DEPTH_MEM-1 in order and captures each returned word. Each word is presented on a valid/ready stream tagged with its address and a last flag. It also accumulates a 32-bit checksum, so reinitialised memory contents can be read back and verified in hardware.

Parameters:
WID_MEM, 18, data width of the memory word.
DEPTH_MEM, 4096, number of words swept; power of two required.
ADDR_W, 12, address width; must equal $clog2(DEPTH_MEM).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-low reset.
start  in  1  sweep request; sampled only in IDLE.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  single-cycle pulse after the last word handshakes.
mem_raddr  out  ADDR_W  read address to memory.
mem_dout  in  WID_MEM  memory read data, valid 1 cycle after mem_raddr.
m_valid  out  1  output word valid.
m_ready  in  1  downstream accept.
m_data  out  WID_MEM  captured word.
m_addr  out  ADDR_W  address of m_data.
m_last  out  1  high with the word at address DEPTH_MEM-1.
checksum  out  32  running sum of handshaken words.

Behaviour:
- Reset value of every output is 0 while reset==0 at a clock edge. In-flight read is discarded, skid buffer is emptied, state returns to IDLE, checksum is cleared. Reset mid-sweep aborts without a done pulse.
- States:
  - IDLE: start==1 moves to SWEEP; issue address is cleared to 0 and checksum is cleared.
  - SWEEP: reads are issued. After address DEPTH_MEM-1 is issued, move to DRAIN.
  - DRAIN: wait until no read is in flight and the buffer is empty, then move to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
  - start outside IDLE is ignored.
- Read issue:
  - Define occ = inflight + count - (m_valid & m_ready), where count is buffer occupancy (0..2).
  - Issue a read in SWEEP when occ <= 1. The issued address is driven on mem_raddr and inflight is set for the next cycle.
  - mem_raddr holds its last value when no read is issued.
- Capture: when inflight==1, mem_dout and its address are written into a 2-entry FIFO. The FIFO head drives m_data, m_addr and m_last, with m_valid = (count != 0).
- Latency: start high in cycle 0 gives mem_raddr=0 in cycle 1 and m_valid with m_addr=0 in cycle 3. With m_ready held at 1 throughput is one word per cycle.
- Handshake:
  - A transfer occurs when m_valid & m_ready.
  - m_data, m_addr and m_last are stable while m_valid=1 and m_ready=0.
  - No word is lost or duplicated under any m_ready pattern.
  - Simultaneous push and pop in the same cycle is legal when the FIFO is full.
- Checksum: on each transfer, checksum <= checksum + zero-extended m_data, mod 2^32.
- Address wrap: the issue counter stops at DEPTH_MEM-1; it never wraps within a sweep.
- done is asserted the cycle after DRAIN completes. busy falls in the same cycle that done is high.

Optional Feature:
MEM_SWEEP_CMP_EN
- Defined:
  - Adds input exp_data[WID_MEM] and outputs err_count[16] and err_first_addr[ADDR_W].
  - exp_data is sampled on each transfer. If it differs from m_data, err_count increments, saturating at 0xFFFF.
  - err_first_addr latches the address of the first mismatch.
  - Both outputs clear on reset and when start is accepted.
- Undefined: the extra ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_sweep_pkg holds:
  - state enum {IDLE, SWEEP, DRAIN, DONE};
  - CHK_W=32 and ERR_W=16.
- Sub-module mem_sweep_skid: a 2-entry FIFO of {addr, data, last} with push, pop, count, head outputs and a synchronous active-low reset.

Test Plan:
- Memory init word[i]=i, m_ready=1, start pulse in cycle 0 -> mem_raddr=0 in cycle 1; first m_valid in cycle 3 with m_addr=0; m_last with m_addr=0xFFF in cycle 4098; done in cycle 4099; checksum=0x007FF800.
- Same init, m_ready random at 50% -> 4096 transfers in strict address order, no gaps or duplicates; outputs stable under stall; checksum=0x007FF800.
- m_ready=0 for 20 cycles after start -> at most 2 reads issued, count=2, mem_raddr stops at 1; on releasing m_ready, the stream resumes at m_addr=0.
- reset=0 at word 100 mid-sweep -> next cycle all outputs 0 and state IDLE with no done pulse; a new start gives a full sweep with the correct checksum.
- start re-asserted while busy -> ignored; exactly one done pulse and one sweep.
- With MEM_SWEEP_CMP_EN, exp_data=i except at i=7 and i=300 -> err_count=2, err_first_addr=7.

Source files
------------

// File: rtl/mem_sweep_pkg.sv
// Shared types and constants for the memory sweep reader.
package mem_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int CHK_W = 32;
    localparam int ERR_W = 16;

    // Checksum accumulation wraps modulo 2^CHK_W.
    function automatic logic [CHK_W-1:0] chk_add(input logic [CHK_W-1:0] acc,
                                                 input logic [CHK_W-1:0] word);
        return acc + word;
    endfunction

endpackage

// File: rtl/mem_sweep_reader_if.sv
// Output word stream of the sweep reader: valid/ready with address and last tag.
interface mem_sweep_reader_if #(
    parameter int WID_MEM = 18,
    parameter int ADDR_W  = 12
);
    logic               m_valid;
    logic               m_ready;
    logic [WID_MEM-1:0] m_data;
    logic [ADDR_W-1:0]  m_addr;
    logic               m_last;

    modport master (output m_valid, m_data, m_addr, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_addr, m_last, output m_ready);
endinterface

// File: rtl/mem_sweep_skid.sv
// Two-entry FIFO holding captured {addr, data, last} words; head is shown combinationally.
module mem_sweep_skid #(
    parameter int W = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] ent_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         pop_ok_s;
    logic         push_ok_s;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign pop_ok_s  = pop & (count_r != 2'd0);
    assign push_ok_s = push & ((count_r != 2'd2) | pop_ok_s);
    assign head      = ent_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ent_r[0] <= '0;
            ent_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                ent_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_sweep_reader.sv
// Sweeps a 1-cycle-latency block RAM from address 0 to DEPTH_MEM-1 and streams each word
// with a running checksum. Optional compare port block: MEM_SWEEP_CMP_EN.
module mem_sweep_reader
    import mem_sweep_pkg::*;
#(
    parameter int WID_MEM   = 18,
    parameter int DEPTH_MEM = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_raddr,
    input  logic [WID_MEM-1:0]  mem_dout,
    mem_sweep_reader_if.master  m_if,
    output logic [CHK_W-1:0]    checksum
`ifdef MEM_SWEEP_CMP_EN
    ,
    input  logic [WID_MEM-1:0]  exp_data,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   err_first_addr
`endif
);

    localparam int ENT_W = ADDR_W + WID_MEM + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

    state_e              state_r;
    state_e              state_nx_s;
    logic [ADDR_W-1:0]   next_addr_r;
    logic [ADDR_W-1:0]   last_addr_r;
    logic                inflight_r;
    logic [ADDR_W-1:0]   inflight_addr_r;
    logic                busy_r;
    logic                done_r;
    logic [CHK_W-1:0]    checksum_r;
    logic                issue_s;
    logic                start_acc_s;
    logic                pop_s;
    logic [2:0]          occ_s;
    logic [1:0]          count_s;
    logic [ENT_W-1:0]    head_s;

    mem_sweep_skid #(.W(ENT_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_r),
        .pop   (pop_s),
        .din   ({inflight_addr_r, mem_dout, (inflight_addr_r == LAST_ADDR)}),
        .head  (head_s),
        .count (count_s)
    );

    assign m_if.m_valid = (count_s != 2'd0);
    assign m_if.m_addr  = head_s[ENT_W-1 -: ADDR_W];
    assign m_if.m_data  = head_s[WID_MEM:1];
    assign m_if.m_last  = head_s[0];
    assign pop_s        = m_if.m_valid & m_if.m_ready;

    // Words already committed to the FIFO once this cycle's pop is accounted for.
    assign occ_s = {2'b00, inflight_r} + {1'b0, count_s} - {2'b00, pop_s};

    // The address is shown only while a read is issued; otherwise the last issued one is held.
    assign mem_raddr = issue_s ? next_addr_r : last_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign checksum  = checksum_r;

    // Next-state and read-issue decision.
    always_comb begin
        state_nx_s  = state_r;
        issue_s     = 1'b0;
        start_acc_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s  = SWEEP;
                    start_acc_s = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SWEEP: begin
                if (occ_s <= 3'd1) begin
                    issue_s = 1'b1;
                    if (next_addr_r == LAST_ADDR) begin
                        state_nx_s = DRAIN;
                    end else begin
                        state_nx_s = SWEEP;
                    end
                end else begin
                    state_nx_s = SWEEP;
                end
            end
            DRAIN: begin
                if (occ_s == 3'd0) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, issue counter, in-flight tracking, status flags and checksum.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= IDLE;
            next_addr_r     <= '0;
            last_addr_r     <= '0;
            inflight_r      <= 1'b0;
            inflight_addr_r <= '0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            checksum_r      <= '0;
        end else begin
            state_r    <= state_nx_s;
            busy_r     <= (state_nx_s == SWEEP) || (state_nx_s == DRAIN);
            done_r     <= (state_nx_s == DONE);
            inflight_r <= issue_s;
            if (issue_s) begin
                last_addr_r     <= next_addr_r;
                inflight_addr_r <= next_addr_r;
                if (next_addr_r != LAST_ADDR) begin
                    next_addr_r <= next_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end else if (start_acc_s) begin
                next_addr_r <= '0;
            end
            if (start_acc_s) begin
                checksum_r <= '0;
            end else if (pop_s) begin
                checksum_r <= chk_add(checksum_r, CHK_W'(m_if.m_data));
            end
        end
    end

`ifdef MEM_SWEEP_CMP_EN
    logic [ERR_W-1:0]  err_count_r;
    logic [ADDR_W-1:0] err_first_addr_r;

    assign err_count      = err_count_r;
    assign err_first_addr = err_first_addr_r;

    // Mismatch counter (saturating) and first mismatching address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_count_r      <= '0;
            err_first_addr_r <= '0;
        end else if (start_acc_s) begin
            err_count_r      <= '0;
            err_first_addr_r <= '0;
        end else if (pop_s && (exp_data != m_if.m_data)) begin
            if (err_count_r != {ERR_W{1'b1}}) begin
                err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
            end
            if (err_count_r == {ERR_W{1'b0}}) begin
                err_first_addr_r <= m_if.m_addr;
            end
        end
    end
`endif

endmodule
